intpol2_d4_decim: RTL and testbench

Decimate-by-4 second-order CIC (sinc^2) filter. It is the rate-reducing counterpart of the D4 interpolator datapath: it consumes 4x-rate samples and emits one 1x-rate sample per 4 accepted inputs. It sits at the receive/analysis end of the interpolation chain. Ready/valid handshakes are used on both sides.

---
 rtl/intpol2_d4_decim.sv | 85 ++++++++
 tb/tb_intpol2_d4_decim.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/intpol2_d4_decim.sv
// Decimate-by-4 second-order CIC (sinc^2) filter with ready/valid on both sides.
// Two wrapping integrators run at the input rate; a two-stage comb runs once
// per group of four accepted inputs and feeds a single held output register.
module intpol2_d4_decim #(
    parameter int DATA_WIDTH = 32,
    parameter int N_bits     = 4,
    localparam int W         = DATA_WIDTH + N_bits
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clear,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic                         valid_in,
    output logic                         ready_in,
    output logic signed [W-1:0]          y,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [1:0]                   phase
);

    // Integrator and comb state; all arithmetic wraps modulo 2^W on purpose,
    // the comb differences cancel any integrator overflow.
    logic signed [W-1:0] i1;
    logic signed [W-1:0] i2;
    logic signed [W-1:0] i2_d;
    logic signed [W-1:0] c1_d;

    logic signed [W-1:0] x_ext;
    logic signed [W-1:0] i1_n;
    logic signed [W-1:0] i2_n;
    logic signed [W-1:0] c1;
    logic signed [W-1:0] y_n;
    logic                accept;
    logic                decim;

    // Input stalls only while a finished output is held and not taken.
    assign ready_in = !valid_out || ready_out;
    assign accept   = valid_in && ready_in;
    assign decim    = accept && (phase == 2'd3);

    // Next-state datapath: I2 integrates the already-updated I1 value.
    assign x_ext = {{N_bits{x[DATA_WIDTH-1]}}, x};
    assign i1_n  = i1 + x_ext;
    assign i2_n  = i2 + i1_n;
    assign c1    = i2_n - i2_d;
    assign y_n   = c1 - c1_d;

    // Integrators, phase counter, comb delays and the held output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i1        <= '0;
            i2        <= '0;
            i2_d      <= '0;
            c1_d      <= '0;
            y         <= '0;
            valid_out <= 1'b0;
            phase     <= 2'd0;
        end else if (clear) begin
            i1        <= '0;
            i2        <= '0;
            i2_d      <= '0;
            c1_d      <= '0;
            y         <= '0;
            valid_out <= 1'b0;
            phase     <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; the comb terms above already see the new I2.
            if (accept) begin
                i1    <= i1_n;
                i2    <= i2_n;
                phase <= phase + 2'd1;
            end
            if (decim) begin
                y         <= y_n;
                i2_d      <= i2_n;
                c1_d      <= c1;
                valid_out <= 1'b1;
            end else if (valid_out && ready_out) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_intpol2_d4_decim.sv
// Self-checking bench for intpol2_d4_decim: a per-cycle vector table for the
// step/backpressure/idle behaviour, then hand-written reset, clear, impulse,
// sparse-input and narrow-width wrap-around sequences.
module tb_intpol2_d4_decim;

    logic               clk;
    logic               rstn;
    logic               clear;
    logic signed [31:0] x;
    logic               valid_in;
    logic               ready_in;
    logic signed [35:0] y;
    logic               valid_out;
    logic               ready_out;
    logic [1:0]         phase;

    // Narrow instance for the wrap-around case (DATA_WIDTH 8, W 12).
    logic signed [7:0]  s_x;
    logic               s_valid_in;
    logic               s_ready_in;
    logic signed [11:0] s_y;
    logic               s_valid_out;
    logic               s_ready_out;
    logic [1:0]         s_phase;

    int checks = 0;
    int errors = 0;

    intpol2_d4_decim #(.DATA_WIDTH(32), .N_bits(4)) dut (
        .clk(clk), .rstn(rstn), .clear(clear), .x(x), .valid_in(valid_in),
        .ready_in(ready_in), .y(y), .valid_out(valid_out),
        .ready_out(ready_out), .phase(phase)
    );

    intpol2_d4_decim #(.DATA_WIDTH(8), .N_bits(4)) dut_s (
        .clk(clk), .rstn(rstn), .clear(1'b0), .x(s_x), .valid_in(s_valid_in),
        .ready_in(s_ready_in), .y(s_y), .valid_out(s_valid_out),
        .ready_out(s_ready_out), .phase(s_phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        vin;
        int          xv;
        logic        rout;
        logic        exp_rdy;
        logic        exp_vout;
        longint      exp_y;
        int          exp_phase;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_pulse();
        clear     = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Feed 12 samples with a single 1 at position pos, expect three outputs.
    task automatic impulse(input int pos, input longint e0, input longint e1,
                           input longint e2, input string nm);
        longint exp_q[3];
        int n;
        exp_q = '{e0, e1, e2};
        n = 0;
        clear_pulse();
        for (int i = 0; i < 12; i++) begin
            valid_in  = 1'b1;
            x         = (i == pos) ? 32'sd1 : 32'sd0;
            ready_out = 1'b1;
            @(posedge clk);
            #1;
            if (valid_out) begin
                if (n < 3) check($sformatf("%s y%0d", nm, n), y, exp_q[n]);
                n++;
            end
        end
        check({nm, " count"}, n, 3);
        valid_in = 1'b0;
    endtask

    initial begin
        int acc;
        int outs;

        rstn = 1'b0; clear = 1'b0; x = '0; valid_in = 1'b0; ready_out = 1'b1;
        s_x = '0; s_valid_in = 1'b0; s_ready_out = 1'b1;

        // Step response with a 5-cycle stall on the first output and one
        // idle cycle carrying a junk x value.
        vecs.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b0,  0, 1});
        vecs.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b0,  0, 2});
        vecs.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b0,  0, 3});
        vecs.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b1, 10, 0});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b1, 1, 1'b0, 1'b0, 1'b1, 10, 0});
        vecs.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b0, 10, 1});
        vecs.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b0, 10, 2});
        vecs.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b0, 10, 3});
        vecs.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b1, 16, 0});
        vecs.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b0, 16, 1});
        vecs.push_back('{1'b0, 5, 1'b1, 1'b1, 1'b0, 16, 1});
        vecs.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b0, 16, 2});
        vecs.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b0, 16, 3});
        vecs.push_back('{1'b1, 1, 1'b1, 1'b1, 1'b1, 16, 0});

        #12;
        check("reset y", y, 0);
        check("reset valid_out", valid_out, 0);
        check("reset phase", phase, 0);
        check("reset ready_in", ready_in, 1);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            valid_in  = vecs[i].vin;
            x         = vecs[i].xv;
            ready_out = vecs[i].rout;
            #1;
            check($sformatf("vec%0d ready_in", i), ready_in, vecs[i].exp_rdy);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d valid_out", i), valid_out, vecs[i].exp_vout);
            check($sformatf("vec%0d y", i), y, vecs[i].exp_y);
            check($sformatf("vec%0d phase", i), phase, vecs[i].exp_phase);
        end

        // Asynchronous reset mid-group after two accepts.
        for (int i = 0; i < 2; i++) begin
            valid_in = 1'b1; x = 1; ready_out = 1'b1;
            @(posedge clk);
            #1;
        end
        check("pre-reset phase", phase, 2);
        valid_in = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("async reset y", y, 0);
        check("async reset valid_out", valid_out, 0);
        check("async reset phase", phase, 0);
        check("async reset ready_in", ready_in, 1);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Clean integrators after reset give the startup value again, then
        // clear mid-group (with valid_in high) must act like reset.
        for (int i = 0; i < 6; i++) begin
            valid_in = 1'b1; x = 1; ready_out = 1'b1;
            @(posedge clk);
            #1;
            if (i == 3) check("post-reset first y", y, 10);
        end
        check("pre-clear phase", phase, 2);
        clear = 1'b1; valid_in = 1'b1; x = 7;
        @(posedge clk);
        #1;
        clear = 1'b0; valid_in = 1'b0;
        check("clear y", y, 0);
        check("clear valid_out", valid_out, 0);
        check("clear phase", phase, 0);
        check("clear ready_in", ready_in, 1);

        // Impulse alignment within a group.
        impulse(0, 4, 0, 0, "impulse first");
        impulse(3, 1, 3, 0, "impulse fourth");

        // Sparse input: phase follows accepted samples only.
        clear_pulse();
        acc = 0;
        outs = 0;
        for (int i = 0; i < 120; i++) begin
            valid_in  = 1'($urandom_range(0, 1));
            x         = -3;
            ready_out = 1'b1;
            @(posedge clk);
            #1;
            if (valid_in) acc++;
            check($sformatf("sparse phase %0d", i), phase, acc % 4);
            if (valid_out) begin
                check($sformatf("sparse y%0d", outs), y, (outs == 0) ? -30 : -48);
                outs++;
            end
        end
        check("sparse output count", outs >= 5, 1);
        valid_in = 1'b0;

        // Wrap-around on the narrow instance: I2 overflows 12 bits, y does not.
        outs = 0;
        for (int i = 0; i < 64; i++) begin
            s_valid_in = 1'b1; s_x = 8'sd127; s_ready_out = 1'b1;
            @(posedge clk);
            #1;
            if (s_valid_out) begin
                check($sformatf("wrap y%0d", outs), s_y, (outs == 0) ? 1270 : 2032);
                outs++;
            end
        end
        check("wrap output count", outs, 16);
        s_valid_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
